hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core.
- Detects load-use hazards and inserts bubbles.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding.
- Flushes wrong-path instructions on taken branches and jumps.
- Parks the core on halt.
- Drives the per-stage write enables and flush controls, plus the evaluation strobe of the forwarding unit, and keeps stall/flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle between the RV32I datapath and hazard_ctrl.
// The datapath drives the master side; the controller receives on the slave side.
interface hazard_ctrl_if;
  logic [31:0] inst_ID;
  logic [31:0] inst_EX;
  logic        nop_EX;
  logic        taken_EX;
  logic        dmem_req;
  logic        dmem_ready;
  logic        halt_WB;
  logic        PC_write;
  logic        IF_ID_write;
  logic        ID_EX_write;
  logic        EX_MEM_write;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        fu;

  modport master (
    output inst_ID, inst_EX, nop_EX, taken_EX, dmem_req, dmem_ready, halt_WB,
    input  PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
           IF_ID_flush, ID_EX_flush, fu
  );

  modport slave (
    input  inst_ID, inst_EX, nop_EX, taken_EX, dmem_req, dmem_ready, halt_WB,
    output PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
           IF_ID_flush, ID_EX_flush, fu
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use bubbles,
// memory freeze, taken-redirect flushes, halt parking and stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  hazard_ctrl_if.slave     pipe,
  output logic             HALT,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;

  logic [6:0] op_id, op_ex;
  logic [4:0] rd_ex, rs1_id, rs2_id;
  logic       rs1_used, rs2_used;
  logic       load_use, frozen, redirect;
  logic       pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl, halt_o;
  logic       unused_inst_bits;

  assign op_id  = pipe.inst_ID[6:0];
  assign rs1_id = pipe.inst_ID[19:15];
  assign rs2_id = pipe.inst_ID[24:20];
  assign op_ex  = pipe.inst_EX[6:0];
  assign rd_ex  = pipe.inst_EX[11:7];
  assign unused_inst_bits = ^{pipe.inst_ID[31:25], pipe.inst_ID[14:7],
                              pipe.inst_EX[31:12]};

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (op_id)
      OP_R, OP_STORE, OP_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: rs1_used = 1'b1;
      default: ;
    endcase
  end

  // Only checked in RUN: the cycle after a bubble or a memory release never
  // re-detects, so a single bubble always resolves the dependency.
  assign load_use = (state == RUN) && (op_ex == OP_LOAD) && !pipe.nop_EX &&
                    (rd_ex != 5'd0) &&
                    ((rs1_used && (rs1_id == rd_ex)) ||
                     (rs2_used && (rs2_id == rd_ex)));

  // dmem_req is the MEM stage's valid, dmem_ready the memory's ready; the
  // access completes in the cycle both are high, and the core freezes while
  // dmem_req is high and dmem_ready is low.
  assign frozen = pipe.dmem_req && !pipe.dmem_ready;

  always_comb begin
    state_nx = state;
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    idex_we  = 1'b1;
    exmem_we = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    halt_o   = 1'b0;
    redirect = 1'b0;
    if (state == HALTED) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      halt_o   = 1'b1;
    end else if (pipe.halt_WB) begin
      // Front end parks; EX/MEM and MEM/WB still load so the halt retires.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      state_nx = HALTED;
    end else if (frozen) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      state_nx = MEM_WAIT;
    end else if (pipe.taken_EX) begin
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      redirect = 1'b1;
      state_nx = RUN;
    end else if (load_use) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_fl  = 1'b1;
      state_nx = LD_STALL;
    end else begin
      state_nx = RUN;
    end
    if (RST) begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      ifid_fl  = 1'b0;
      idex_fl  = 1'b0;
      halt_o   = 1'b0;
      redirect = 1'b0;
      state_nx = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= state_nx;
      if ((state != HALTED) && !pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
      // wait_cnt holds the number of frozen cycles completed in this wait.
      if (state_nx == MEM_WAIT) begin
        if (wait_cnt != WAIT_W'(MAX_WAIT))
          wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= WAIT_W'(MAX_WAIT - 1))
          err_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign pipe.PC_write     = pc_we;
  assign pipe.IF_ID_write  = ifid_we;
  assign pipe.ID_EX_write  = idex_we;
  assign pipe.EX_MEM_write = exmem_we;
  assign pipe.IF_ID_flush  = ifid_fl;
  assign pipe.ID_EX_flush  = idex_fl;
  assign pipe.fu           = !RST && (state != HALTED) && (idex_we || idex_fl);
  assign HALT              = halt_o;
  assign state_dbg         = state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then randomized traffic, all
// checked against a cycle-level behavioural model of the sequencing rules.
module tb_hazard_ctrl;
  localparam int CNT_W    = 2;
  localparam int MAX_WAIT = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if pipe ();
  logic             halt, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       state_dbg;

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(clk), .RST(rst), .pipe(pipe), .HALT(halt), .err_timeout(err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural model state
  bit m_halted, m_after_bubble, m_after_wait, m_err;
  int m_wait, m_stall, m_flush;
  logic [7:0] exp_q[$];

  function automatic logic [31:0] enc(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                      logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, rd, op};
  endfunction

  function automatic bit reads_rs1(logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_JALR, OP_BRANCH};
  endfunction

  function automatic bit reads_rs2(logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

  function automatic bit hazard_pair(logic [31:0] ex, logic [31:0] id, bit nop);
    logic [4:0] rd;
    rd = ex[11:7];
    if (ex[6:0] != OP_LOAD || nop || rd == 5'd0) return 1'b0;
    return (reads_rs1(id[6:0]) && id[19:15] == rd) || (reads_rs2(id[6:0]) && id[24:20] == rd);
  endfunction

  function automatic int sat(int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_after_bubble = 0; m_after_wait = 0; m_err = 0;
    m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  // driver tasks
  task automatic drive(input logic [31:0] id, input logic [31:0] ex, input bit nop,
                       input bit tk, input bit req, input bit rdy, input bit hw);
    pipe.inst_ID = id; pipe.inst_EX = ex; pipe.nop_EX = nop; pipe.taken_EX = tk;
    pipe.dmem_req = req; pipe.dmem_ready = rdy; pipe.halt_WB = hw;
  endtask

  // One clock: predict, compare mid-cycle, then advance the model at the edge.
  // Vector order: PC, IF_ID_w, ID_EX_w, EX_MEM_w, IF_ID_fl, ID_EX_fl, fu, HALT.
  task automatic cycle();
    logic [7:0] e;
    bit fr, tk, hw, lu;
    fr = pipe.dmem_req && !pipe.dmem_ready;
    tk = pipe.taken_EX;
    hw = pipe.halt_WB;
    lu = !m_after_bubble && !m_after_wait &&
         hazard_pair(pipe.inst_EX, pipe.inst_ID, pipe.nop_EX);
    if (rst)           e = 8'b1111_0000;
    else if (m_halted) e = 8'b0000_0001;
    else if (hw)       e = 8'b0001_0000;
    else if (fr)       e = 8'b0000_0000;
    else if (tk)       e = 8'b1111_1110;
    else if (lu)       e = 8'b0011_0110;
    else               e = 8'b1111_0010;
    exp_q.push_back(e);
    @(negedge clk);
    check("ctrl", {pipe.PC_write, pipe.IF_ID_write, pipe.ID_EX_write, pipe.EX_MEM_write,
                   pipe.IF_ID_flush, pipe.ID_EX_flush, pipe.fu, halt}, exp_q.pop_front());
    check("stall_cnt", stall_cnt, sat(m_stall));
    check("flush_cnt", flush_cnt, sat(m_flush));
    check("err_timeout", err, m_err);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_halted) begin
      if (!e[7]) m_stall++;
      if (!hw && !fr && tk) m_flush++;
      if (!hw && fr) begin
        m_wait++;
        if (m_wait >= MAX_WAIT) m_err = 1;
      end else begin
        m_wait = 0;
      end
      m_after_bubble = !hw && !fr && !tk && lu;
      m_after_wait   = !hw && fr;
      m_halted       = hw;
    end
    #1;
  endtask

  task automatic reset_step();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst(bit load_bias);
    logic [6:0] ops[8];
    logic [31:0] r;
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_JALR, OP_BRANCH, OP_LUI, OP_JAL};
    r = $urandom;
    r[6:0]   = (load_bias && $urandom_range(0, 1) == 0) ? OP_LOAD : ops[$urandom_range(0, 7)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    logic [31:0] lw_x5, lw_x0, add_dep, add_x0, addi_imm5, nop_i;
    int burst, halted_for;
    lw_x5     = enc(OP_LOAD, 5'd5, 5'd1, 5'd0);
    lw_x0     = enc(OP_LOAD, 5'd0, 5'd1, 5'd0);
    add_dep   = enc(OP_R, 5'd6, 5'd5, 5'd2);
    add_x0    = enc(OP_R, 5'd6, 5'd0, 5'd0);
    addi_imm5 = enc(OP_IMM, 5'd6, 5'd7, 5'd5);
    nop_i     = enc(OP_IMM, 5'd0, 5'd0, 5'd0);

    drive(nop_i, nop_i, 1, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_step();

    // load-use: one bubble then normal advance
    drive(add_dep, lw_x5, 0, 0, 0, 0, 0); cycle();
    check("lu_stall_cnt", stall_cnt, 1);
    drive(add_dep, lw_x5, 1, 0, 0, 0, 0); cycle();
    check("lu_pc_resumes", pipe.PC_write, 1);

    // no stall for x0 destination or for an unused rs2 field
    drive(add_x0, lw_x0, 0, 0, 0, 0, 0);     cycle();
    drive(addi_imm5, lw_x5, 0, 0, 0, 0, 0);  cycle();
    check("no_stall_cnt", stall_cnt, 1);

    // redirect suppresses load-use
    reset_step();
    drive(add_dep, lw_x5, 0, 1, 0, 0, 0); cycle();
    check("redirect_flush_cnt", flush_cnt, 1);
    check("redirect_stall_cnt", stall_cnt, 0);
    drive(nop_i, nop_i, 1, 0, 0, 0, 0); cycle();

    // 3-cycle freeze with taken held, single flush on release
    reset_step();
    repeat (3) begin drive(nop_i, nop_i, 0, 1, 1, 0, 0); cycle(); end
    check("freeze_stall_cnt", stall_cnt, 3);
    check("freeze_no_flush", flush_cnt, 0);
    drive(nop_i, nop_i, 0, 1, 1, 1, 0); cycle();
    drive(nop_i, nop_i, 1, 0, 0, 0, 0); cycle();
    check("freeze_flush_cnt", flush_cnt, 1);

    // timeout: err rises after MAX_WAIT frozen cycles, sticky, cleared by reset
    reset_step();
    repeat (MAX_WAIT - 1) begin drive(nop_i, nop_i, 0, 0, 1, 0, 0); cycle(); end
    check("timeout_early", err, 0);
    drive(nop_i, nop_i, 0, 0, 1, 0, 0); cycle();
    check("timeout_set", err, 1);
    repeat (2) cycle();
    check("timeout_sticky", err, 1);
    reset_step();
    check("timeout_rst_err", err, 0);
    check("timeout_rst_stall", stall_cnt, 0);
    drive(nop_i, nop_i, 1, 0, 0, 0, 0); cycle();

    // saturation: five load-use bubbles on a 2-bit counter
    repeat (5) begin
      drive(add_dep, lw_x5, 0, 0, 0, 0, 0); cycle();
      drive(add_dep, lw_x5, 1, 0, 0, 0, 0); cycle();
    end
    check("sat_stall_cnt", stall_cnt, CNT_MAX);

    // halt: parks next cycle, everything frozen until reset
    drive(add_dep, lw_x5, 0, 1, 1, 0, 1); cycle();
    drive(add_dep, lw_x5, 0, 1, 1, 0, 0);
    repeat (3) cycle();
    check("halt_out", halt, 1);
    check("halt_flush_frozen", flush_cnt, 0);
    reset_step();
    check("halt_rst_out", halt, 0);

    // randomized traffic
    burst = 0;
    halted_for = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] id, ex;
      bit req, rdy;
      id = rand_inst(0);
      ex = rand_inst(1);
      if (burst > 0) begin
        req = 1; rdy = 0; burst--;
      end else begin
        req = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 19) == 0) burst = $urandom_range(2, 6);
      end
      drive(id, ex, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, req, rdy,
            $urandom_range(0, 99) == 0);
      halted_for = m_halted ? halted_for + 1 : 0;
      rst = (halted_for > 4) || ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
